framebuffer_scan_reader: RTL and testbench

//   Read side of the 640x480 paint frame buffer: turns the VGA scan position into BRAM read

---
 rtl/fb_pkg.sv | 38 +++
 rtl/delay_pipe.sv | 47 ++++
 rtl/framebuffer_scan_reader.sv | 176 +++++++++++++++++
 tb/tb_framebuffer_scan_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_pkg
//  Purpose  : Shared types, frame geometry, scan-reader states and the
//             3-bit to 4:4:4 colour expansion for the paint frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int MEM_WIDTH  = 640;
  localparam int MEM_HEIGHT = 480;

  // Stored pixel, one bit per primary: {R,G,B}
  typedef logic [2:0] pixel_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    WAIT_INIT  = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } fb_state_e;

  // A set bit drives its DAC channel full scale, a clear bit drives it to zero
  function automatic rgb444_t expand_pixel(input pixel_t p);
    rgb444_t c;
    c.r = {4{p[2]}};
    c.g = {4{p[1]}};
    c.b = {4{p[0]}};
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : delay_pipe
//  Purpose  : Resettable shift register of DEPTH stages, WIDTH bits wide.
//             Every stage loads RESET_VAL on reset so a flushed pipe only
//             ever presents the inactive value.
//  Revision : 1.0 - initial release
// ============================================================================
module delay_pipe #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Each stage takes the value of the one before it; stage 0 takes the input
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, all forced to the inactive value on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/framebuffer_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_scan_reader
//  Purpose  : Read side of the 640x480 paint frame buffer. Converts the scan
//             position to a BRAM read address, re-aligns syncs and video_on
//             with the read latency, expands stored colour to RGB444 and
//             blanks the picture until the buffer is initialised and a new
//             frame has started.
//  Options  : CURSOR_OVERLAY_EN - draw an inverted square cursor outline.
//  Revision : 1.0 - initial release
// ============================================================================
module framebuffer_scan_reader #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 3,
  parameter int MEM_WIDTH  = fb_pkg::MEM_WIDTH,
  parameter int MEM_HEIGHT = fb_pkg::MEM_HEIGHT,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  init_done,
  input  logic [9:0]            cursor_x,
  input  logic [9:0]            cursor_y,
  input  logic [3:0]            brushSize,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_active
);

  import fb_pkg::*;

  // Address register + BRAM latency + colour output register
  localparam int PIPE = RD_LATENCY + 2;
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(MEM_WIDTH);

  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  fb_state_e             state_d, state_q;
  logic                  vsync_prev_d, vsync_prev_q;
  rgb444_t               rgb_d, rgb_q;
  pixel_t                pix;
  logic                  video_on_dly;
  logic [1:0]            sync_dly;

  // Linear address of the scan position; off-frame positions read address 0
  always_comb begin
    addr_d = '0;
    if ((int'(x) < MEM_WIDTH) && (int'(y) < MEM_HEIGHT)) begin
      addr_d = ADDR_WIDTH'(y) * ROW_STRIDE + ADDR_WIDTH'(x);
    end
  end

  // Syncs travel the full pipeline so they leave together with the colour
  delay_pipe #(
    .WIDTH     (2),
    .DEPTH     (PIPE),
    .RESET_VAL (2'b11)
  ) u_sync_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({hsync_in, vsync_in}),
    .dout (sync_dly)
  );

`ifdef CURSOR_OVERLAY_EN
  logic [20:0]        vid_dly;
  logic [9:0]         x_dly, y_dly;
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady, dist;
  logic               on_cursor;

  // video_on and position arrive at the colour logic together with the read data
  delay_pipe #(
    .WIDTH     (21),
    .DEPTH     (PIPE - 1),
    .RESET_VAL (21'd0)
  ) u_video_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({video_on, x, y}),
    .dout (vid_dly)
  );

  assign video_on_dly = vid_dly[20];
  assign x_dly        = vid_dly[19:10];
  assign y_dly        = vid_dly[9:0];

  // Chebyshev distance from the cursor; 11-bit signed so x=0/y=0 never wraps
  always_comb begin
    dx        = $signed({1'b0, x_dly}) - $signed({1'b0, cursor_x});
    dy        = $signed({1'b0, y_dly}) - $signed({1'b0, cursor_y});
    adx       = dx[10] ? 11'(-dx) : 11'(dx);
    ady       = dy[10] ? 11'(-dy) : 11'(dy);
    dist      = (adx > ady) ? adx : ady;
    on_cursor = (dist == {7'd0, brushSize});
  end
`else
  logic unused_cursor;

  // video_on arrives at the colour logic together with the read data
  delay_pipe #(
    .WIDTH     (1),
    .DEPTH     (PIPE - 1),
    .RESET_VAL (1'b0)
  ) u_video_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (video_on),
    .dout (video_on_dly)
  );

  assign unused_cursor = ^{cursor_x, cursor_y, brushSize};
`endif

  // Display state: start only on a frame boundary, drop out whenever init_done falls
  always_comb begin
    state_d      = state_q;
    vsync_prev_d = vsync_in;
    case (state_q)
      WAIT_INIT:  if (init_done) state_d = WAIT_FRAME;
      WAIT_FRAME: if (vsync_prev_q && !vsync_in) state_d = ACTIVE;
      default:    state_d = state_q;
    endcase
    if (!init_done) begin
      state_d = WAIT_INIT;
    end
  end

  // Pixel colour: optional cursor inversion, then expansion, blanked outside ACTIVE/visible
  always_comb begin
    pix = pixel_t'(mem_read_data);
`ifdef CURSOR_OVERLAY_EN
    if (on_cursor) begin
      pix = ~pix;
    end
`endif
    rgb_d = '0;
    if (video_on_dly && (state_q == ACTIVE)) begin
      rgb_d = expand_pixel(pix);
    end
  end

  // Address, state, sync-edge and colour registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      state_q      <= WAIT_INIT;
      vsync_prev_q <= 1'b1;
      rgb_q        <= '0;
    end else begin
      addr_q       <= addr_d;
      state_q      <= state_d;
      vsync_prev_q <= vsync_prev_d;
      rgb_q        <= rgb_d;
    end
  end

  assign mem_read_addr = addr_q;
  assign vga_r         = rgb_q.r;
  assign vga_g         = rgb_q.g;
  assign vga_b         = rgb_q.b;
  assign hsync         = sync_dly[1];
  assign vsync         = sync_dly[0];
  assign frame_active  = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_scan_reader
//  Purpose  : Self-checking bench for framebuffer_scan_reader with a two-cycle
//             BRAM model. Honours CURSOR_OVERLAY_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scan_reader;

  localparam int RD_LAT = 2;
  localparam int PIPE   = RD_LAT + 2;
  localparam int N      = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y, cursor_x, cursor_y;
  logic        video_on, hsync_in, vsync_in, init_done;
  logic [3:0]  brushSize;
  logic [19:0] mem_read_addr;
  logic [2:0]  mem_read_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_active;

  always #5 clk = ~clk;

  framebuffer_scan_reader #(
    .ADDR_WIDTH (20),
    .DATA_WIDTH (3),
    .MEM_WIDTH  (640),
    .MEM_HEIGHT (480),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .y             (y),
    .video_on      (video_on),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .init_done     (init_done),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .brushSize     (brushSize),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_active  (frame_active)
  );

  // ---------------- frame buffer contents and BRAM read model ----------------
  bit          white_mode = 1'b0;
  logic [19:0] salt = 20'd0;

  function automatic logic [2:0] data_of(input logic [19:0] a);
    logic [19:0] t;
    if (white_mode) return 3'b111;
    if (a == 20'd1000) return 3'b101;
    t = a ^ (a >> 5) ^ salt;
    return t[2:0];
  endfunction

  logic [2:0] rd_pipe [RD_LAT] = '{default: 3'b000};
  always @(posedge clk) begin
    rd_pipe[0] <= data_of(mem_read_addr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_read_data = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  int hx [N], hy [N], hcx [N], hcy [N], hbr [N];
  bit hvid [N], hhs [N], hvs [N], hinit [N], hrst [N];
  bit mact [N];
  bit m_armed = 0, m_act = 0, m_vprev = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  function automatic int addr_of(input int px, input int py);
    if (px < 640 && py < 480) return py * 640 + px;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record held inputs, advance, then compare every output with the model
  task automatic tick();
    int n, k, kk, dx, dy;
    bit flushed;
    logic [2:0] pix;
    logic [11:0] exp_rgb;
    logic exp_hs, exp_vs;
    if (cyc >= N - 2) begin
      $display("FAIL history_overflow: observed %0d expected below %0d", cyc, N - 2);
      $fatal(1, "history overflow");
    end
    hx[cyc] = int'(x);  hy[cyc] = int'(y);
    hcx[cyc] = int'(cursor_x); hcy[cyc] = int'(cursor_y); hbr[cyc] = int'(brushSize);
    hvid[cyc] = video_on; hhs[cyc] = hsync_in; hvs[cyc] = vsync_in;
    hinit[cyc] = init_done; hrst[cyc] = rst;
    @(posedge clk);
    cyc++;
    n = cyc;
    k = n - 1;
    // Display enable: needs init_done, then a vsync falling edge after it
    if (hrst[k]) begin
      m_armed = 0; m_act = 0; m_vprev = 1;
    end else begin
      if (!hinit[k]) begin
        m_armed = 0; m_act = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (!m_act && m_vprev && !hvs[k]) begin
        m_act = 1;
      end
      m_vprev = hvs[k];
    end
    mact[n] = m_act;
    @(negedge clk);
    // The pixel now on the pins was presented PIPE cycles ago; any reset since kills it
    kk = n - PIPE;
    flushed = (kk < 0);
    for (int j = (kk < 0 ? 0 : kk); j < n; j++) if (hrst[j]) flushed = 1;
    exp_hs  = flushed ? 1'b1 : hhs[kk];
    exp_vs  = flushed ? 1'b1 : hvs[kk];
    exp_rgb = 12'h000;
    if (!flushed && hvid[kk] && mact[n-1]) begin
      pix = data_of(20'(addr_of(hx[kk], hy[kk])));
`ifdef CURSOR_OVERLAY_EN
      dx = hx[kk] - hcx[n-1]; if (dx < 0) dx = -dx;
      dy = hy[kk] - hcy[n-1]; if (dy < 0) dy = -dy;
      if (((dx > dy) ? dx : dy) == hbr[n-1]) pix = ~pix;
`endif
      exp_rgb = {{4{pix[2]}}, {4{pix[1]}}, {4{pix[0]}}};
    end
    chk("addr", 32'(mem_read_addr), hrst[k] ? 32'd0 : 32'(addr_of(hx[k], hy[k])));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    chk("hsync", 32'(hsync), 32'(exp_hs));
    chk("vsync", 32'(vsync), 32'(exp_vs));
    chk("frame_active", 32'(frame_active), 32'(m_act));
  endtask

  task automatic rand_pixel();
    x = 10'($urandom_range(0, 799));
    y = 10'($urandom_range(0, 524));
    video_on = (x < 10'd640) && (y < 10'd480);
    hsync_in = ($urandom_range(0, 7) != 0);
  endtask

  task automatic idle(input int cycles);
    video_on = 0; hsync_in = 1; vsync_in = 1;
    repeat (cycles) tick();
  endtask

  task automatic vsync_pulse();
    video_on = 0; hsync_in = 1; vsync_in = 0;
    repeat (3) tick();
    vsync_in = 1;
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] ring_exp [5];
  int          ring_x   [5];
  int          ring_y   [5];

  initial begin
    salt = 20'($urandom);
    rst = 1; x = 0; y = 0; video_on = 0; hsync_in = 1; vsync_in = 1; init_done = 0;
    cursor_x = 0; cursor_y = 0; brushSize = 0;

    // Reset state
    repeat (4) tick();
    chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("reset_hsync", 32'(hsync), 32'd1);
    chk("reset_vsync", 32'(vsync), 32'd1);
    chk("reset_frame_active", 32'(frame_active), 32'd0);
    chk("reset_addr", 32'(mem_read_addr), 32'd0);
    rst = 0;

    // Address boundaries
    x = 639; y = 479; tick(); chk("addr_last_pixel", 32'(mem_read_addr), 32'd307199);
    x = 700; y = 10;  tick(); chk("addr_right_of_frame", 32'(mem_read_addr), 32'd0);
    x = 5;   y = 480; tick(); chk("addr_below_frame", 32'(mem_read_addr), 32'd0);

    // Buffer not initialised: always black
    repeat (20) begin rand_pixel(); tick(); end

    // init_done rises mid-frame: still black until the next vsync falling edge
    init_done = 1;
    repeat (30) begin
      rand_pixel(); tick();
      chk("wait_frame_inactive", 32'(frame_active), 32'd0);
    end
    video_on = 0; hsync_in = 1; vsync_in = 0; tick();
    chk("active_after_vsync_fall", 32'(frame_active), 32'd1);
    tick(); tick(); vsync_in = 1;
    idle(PIPE + 2);

    // Single pixel at address 1000 with marked syncs: lands exactly PIPE cycles later
    x = 360; y = 1; video_on = 1; hsync_in = 0; vsync_in = 0; tick();
    video_on = 0; hsync_in = 1; vsync_in = 1; x = 0; y = 0;
    tick(); tick();
    chk("pix1000_not_early", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("hsync_not_early", 32'(hsync), 32'd1);
    tick();
    chk("pix1000_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0F0F);
    chk("pix1000_hsync", 32'(hsync), 32'd0);
    chk("pix1000_vsync", 32'(vsync), 32'd0);
    idle(2);

    // Random scan with periodic frame starts
    for (int i = 0; i < 300; i++) begin
      rand_pixel();
      vsync_in = ((i % 60) < 3) ? 1'b0 : 1'b1;
      tick();
    end
    vsync_in = 1;

    // Dropping init_done disables the display on the next cycle
    init_done = 0; rand_pixel(); tick();
    chk("init_drop_inactive", 32'(frame_active), 32'd0);
    init_done = 1;
    repeat (20) begin rand_pixel(); vsync_in = 1; tick(); end
    vsync_pulse();
    chk("reactivated", 32'(frame_active), 32'd1);

    // Cursor outline on a white buffer, cursor at the origin
    idle(PIPE + 2);
    white_mode = 1; cursor_x = 0; cursor_y = 0; brushSize = 2;
    ring_x = '{2, 2, 0, 1, 3};
    ring_y = '{0, 2, 2, 1, 0};
`ifdef CURSOR_OVERLAY_EN
    ring_exp = '{12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF};
`else
    ring_exp = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
`endif
    for (int t = 0; t < 9; t++) begin
      if (t < 5) begin
        x = 10'(ring_x[t]); y = 10'(ring_y[t]); video_on = 1;
      end else begin
        video_on = 0;
      end
      tick();
      if (t >= 3 && t < 8)
        chk("cursor_ring", 32'({vga_r, vga_g, vga_b}), 32'(ring_exp[t-3]));
    end
    idle(PIPE + 2);
    white_mode = 0;

    // Random pixels around a random cursor
    for (int i = 0; i < 100; i++) begin
      if ((i % 20) == 0) begin
        cursor_x = 10'($urandom_range(0, 20));
        cursor_y = 10'($urandom_range(0, 20));
        brushSize = 4'($urandom_range(0, 15));
      end
      x = 10'($urandom_range(0, 30)); y = 10'($urandom_range(0, 30));
      video_on = 1; hsync_in = 1; vsync_in = 1;
      tick();
    end

    // Reset during an active line: flushes immediately, no stale pixels afterwards
    repeat (10) begin rand_pixel(); x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479)); video_on = 1; tick(); end
    rst = 1; rand_pixel(); hsync_in = 0; vsync_in = 0; tick();
    chk("rst_mid_line_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_mid_line_hsync", 32'(hsync), 32'd1);
    chk("rst_mid_line_vsync", 32'(vsync), 32'd1);
    vsync_in = 1; tick();
    rst = 0;
    repeat (30) begin rand_pixel(); vsync_in = 1; tick(); end
    vsync_pulse();
    repeat (50) begin rand_pixel(); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
